// File: rtl/sw_io_frontend.sv
// sw_io_frontend
// Device-side producer for the switch/pushbutton input word at 0xfff0.
// Each raw asynchronous input is synchronized through two flops and then
// debounced. A new level is accepted only after DEBOUNCE_CYCLES consecutive
// cycles in which the synchronized value differs from the current stable
// level. An accepted pushbutton press sets a sticky flag, pulses pb_event
// and bumps a saturating 8-bit press counter. A read strobe clears the flag.
//
// Ports
//   clock      in   system clock, all state updates on posedge
//   reset      in   synchronous active-high reset, clears every register
//   raw_sw0    in   asynchronous sliding switch 0
//   raw_sw1    in   asynchronous sliding switch 1
//   raw_pb0    in   asynchronous pushbutton 0 (1 = pressed)
//   rd_strobe  in   one-cycle pulse: data memory read of 0xfff0
//   io_sw0     out  debounced SW0 level
//   io_sw1     out  debounced SW1 level
//   io_pb0     out  sticky press flag
//   pb_event   out  one-cycle pulse on an accepted PB0 press
//   io_rdata   out  {press_cnt[7:0], 5'd0, io_sw1, io_sw0, io_pb0}
module sw_io_frontend #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        raw_sw0,
  input  logic        raw_sw1,
  input  logic        raw_pb0,
  input  logic        rd_strobe,
  output logic        io_sw0,
  output logic        io_sw1,
  output logic        io_pb0,
  output logic        pb_event,
  output logic [15:0] io_rdata
);

  localparam int NCH = 3;  // channel 0 = sw0, 1 = sw1, 2 = pb0
  localparam int PB  = 2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0] w_raw;
  logic [NCH-1:0] r_sync_p0;
  logic [NCH-1:0] r_sync_p1;
  logic [NCH-1:0] r_stable;
  logic [CNT_W-1:0] r_cnt [NCH];
  logic [NCH-1:0] w_accept;
  logic           w_pb_rise;
  logic           r_pb_event;
  logic           r_flag;
  logic [7:0]     r_press_cnt;

  assign w_raw = {raw_pb0, raw_sw1, raw_sw0};

  // Acceptance happens on the edge that completes DEBOUNCE_CYCLES mismatches.
  always_comb begin
    w_accept = '0;
    for (int c = 0; c < NCH; c++) begin
      w_accept[c] = (r_sync_p1[c] != r_stable[c]) && (r_cnt[c] == LAST);
    end
  end

  // A press is the stable pb0 level moving 0->1; release produces no event.
  assign w_pb_rise = w_accept[PB] & ~r_stable[PB];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync_p0   <= '0;
      r_sync_p1   <= '0;
      r_stable    <= '0;
      for (int c = 0; c < NCH; c++) begin
        r_cnt[c] <= '0;
      end
      r_pb_event  <= 1'b0;
      r_flag      <= 1'b0;
      r_press_cnt <= '0;
    end else begin
      // p0/p1: two-flop synchronizer
      r_sync_p0 <= w_raw;
      r_sync_p1 <= r_sync_p0;

      // debounce: any matching cycle restarts the count
      for (int c = 0; c < NCH; c++) begin
        if (r_sync_p1[c] == r_stable[c]) begin
          r_cnt[c] <= '0;
        end else if (w_accept[c]) begin
          r_stable[c] <= r_sync_p1[c];
          r_cnt[c]    <= '0;
        end else begin
          r_cnt[c] <= r_cnt[c] + 1'b1;
        end
      end

      // press bookkeeping
      r_pb_event <= w_pb_rise;
      if (w_pb_rise && (r_press_cnt != 8'hFF)) begin
        r_press_cnt <= r_press_cnt + 8'd1;
      end
      // a press landing on the read cycle wins so it is not lost
      if (w_pb_rise) begin
        r_flag <= 1'b1;
      end else if (rd_strobe) begin
        r_flag <= 1'b0;
      end
    end
  end

  assign io_sw0   = r_stable[0];
  assign io_sw1   = r_stable[1];
  assign io_pb0   = r_flag;
  assign pb_event = r_pb_event;
  // Combinational from registers: on a read cycle the pre-clear flag is seen.
  assign io_rdata = {r_press_cnt, 5'd0, r_stable[1], r_stable[0], r_flag};

endmodule
